udp_rx_mux: RTL and testbench
=============================

# udp_rx_mux

Multi-channel UDP receive filter between the IP receive layer and the application layer. Parses the 8-byte UDP header of each byte-serial datagram and matches (source IP, source port) against a runtime-programmable table of `NUM_CH` exchange feeds. On a match it forwards exactly the UDP payload (length-field bounded, trailing padding stripped) tagged with the matching channel index and a last-byte flag. Misses, malformed lengths, truncations and upstream aborts are dropped with a one-cycle drop pulse.

## Interface
- `NUM_CH`, default 4: number of filter entries; legal range 1..16.
- `CH_W`, derived as max(1, clog2(NUM_CH)): width of the channel index.
- `i_sys_clk`  in  1: system clock.
- `i_rstn`  in  1: asynchronous active-low reset.
- `i_datagram_vld`  in  1: high for every byte of one datagram, contiguous; low for at least 1 cycle between datagrams.
- `i_datagram`  in  8: datagram byte, UDP header first, MSB-first fields.
- `i_drop_datagram`  in  1: upstream abort of the current datagram.
- `i_src_ip`  in  32: source IP of the current datagram; stable while `i_datagram_vld` is high.
- `i_cfg_we`  in  1: table write strobe.
- `i_cfg_idx`  in  CH_W: entry written; writes with idx ≥ NUM_CH are ignored.
- `i_cfg_en`  in  1: entry enable.
- `i_cfg_ip`  in  32: entry source IP.
- `i_cfg_port`  in  16: entry source port.
- `o_data_vld`  out  1: payload byte valid.
- `o_data`  out  8: payload byte.
- `o_data_last`  out  1: qualifies the final payload byte.
- `o_ch_id`  out  CH_W: matched entry; valid with `o_data_vld`.
- `o_drop_datagram`  out  1: one-cycle drop pulse.
- `o_len_err`  out  1: one-cycle pulse; the drop was caused by a length fault. Asserted together with `o_drop_datagram`.

## Operation
- Table: NUM_CH entries of {en, ip, port}, all zero (disabled) at reset. Write on `i_cfg_we` and visible to a compare from the next cycle. A write during a datagram does not affect a match already made.
- States: IDLE, HEADER, PAYLOAD, DISCARD. Byte counter `hdr_cnt` is 3 bits; payload remaining counter `rem` is 16 bits.
- IDLE: `i_datagram_vld`=1 accepts byte 0 (src port MSB), then go to HEADER.
- HEADER: latch src port (bytes 0-1), dst port (2-3), length L (4-5); ignore checksum (6-7).
- Compare at byte 7. Hit means the entry is enabled, its ip equals `i_src_ip` and its port equals the latched src port. The lowest-index hit wins.
  - Hit and L>8: go to PAYLOAD, latch `o_ch_id`, load `rem`=L-8.
  - Hit and L=8: back to IDLE via DISCARD. No output, no drop.
  - L<8: drop plus `o_len_err`, go to DISCARD. This takes priority over the hit result.
  - No hit: drop, go to DISCARD.
- PAYLOAD: each accepted byte is forwarded and decrements `rem`. The byte with `rem`=1 carries `o_data_last`, then go to DISCARD, which sinks padding.
  - `i_datagram_vld` falling while `rem`>0: drop plus `o_len_err`, go to IDLE. No `o_data_last` is issued.
- DISCARD: ignore bytes and return to IDLE when `i_datagram_vld`=0.
- `i_drop_datagram` in HEADER or PAYLOAD: drop pulse (no `o_len_err`), no further output, go to DISCARD. It is ignored in IDLE and DISCARD. Abort beats every other event in the same cycle, including the compare and last byte.
- At most one drop pulse per datagram.

## Timing
- All outputs are registered and reset to 0, including `o_ch_id`.
- Latency: payload input byte k (datagram byte 8+k) at cycle t appears on `o_data` at cycle t+1. `o_data_vld` is never high in the cycle after a drop.
- Miss / L<8 drop: pulse in the cycle after byte 7.
- Truncation drop: pulse in the cycle after `i_datagram_vld` falls.
- Abort drop: pulse in the cycle after `i_drop_datagram`.
- `o_ch_id` holds from the first payload byte until the next match.
- Reset mid-datagram: state goes to IDLE and the table is cleared. The remaining bytes of that datagram are treated as a new datagram once reset is released; upstream must not release reset while `i_datagram_vld` is high.
- Back-to-back datagrams separated by 1 idle cycle must be handled with no loss.

## Test plan
- Entry 2 = {en, 10.0.0.5, 0x1F90}, datagram from 10.0.0.5:0x1F90 with L=12 and bytes AA BB CC DD -> 4 `o_data_vld` cycles, starting at cycle t0+9, `o_ch_id`=2, `o_data_last` on DD, no drop.
- Same datagram, L=10, plus 6 padding bytes -> only AA BB are output, `o_data_last` on BB, no drop.
- Entries 1 and 3 both match -> `o_ch_id`=1. Disable entry 1 via cfg write between datagrams -> next datagram has `o_ch_id`=3.
- Source port 0x1F91 -> `o_drop_datagram` at t0+8, `o_len_err`=0, no data. L=6 -> drop plus `o_len_err` at t0+8.
- L=20, `i_datagram_vld` drops after 5 payload bytes -> 5 bytes output, no last, drop plus `o_len_err` one cycle after the fall.
- `i_drop_datagram` at payload byte 2 -> bytes 0-1 only, drop pulse next cycle. Following datagram after a 1-cycle gap matches and forwards normally.

Source files
------------

// File: rtl/udp_rx_mux_if.sv
// rtl/udp_rx_mux_if.sv - datagram, table-config and payload signals of udp_rx_mux
interface udp_rx_mux_if #(
    parameter int CH_W = 2
);
    logic            i_datagram_vld;
    logic [7:0]      i_datagram;
    logic            i_drop_datagram;
    logic [31:0]     i_src_ip;
    logic            i_cfg_we;
    logic [CH_W-1:0] i_cfg_idx;
    logic            i_cfg_en;
    logic [31:0]     i_cfg_ip;
    logic [15:0]     i_cfg_port;
    logic            o_data_vld;
    logic [7:0]      o_data;
    logic            o_data_last;
    logic [CH_W-1:0] o_ch_id;
    logic            o_drop_datagram;
    logic            o_len_err;

    modport slave (
        input  i_datagram_vld, i_datagram, i_drop_datagram, i_src_ip,
        input  i_cfg_we, i_cfg_idx, i_cfg_en, i_cfg_ip, i_cfg_port,
        output o_data_vld, o_data, o_data_last, o_ch_id, o_drop_datagram, o_len_err
    );

    modport master (
        output i_datagram_vld, i_datagram, i_drop_datagram, i_src_ip,
        output i_cfg_we, i_cfg_idx, i_cfg_en, i_cfg_ip, i_cfg_port,
        input  o_data_vld, o_data, o_data_last, o_ch_id, o_drop_datagram, o_len_err
    );
endinterface

// File: rtl/udp_rx_mux.sv
// rtl/udp_rx_mux.sv - UDP receive filter: matches (src ip, src port) against a
// programmable table and forwards the length-bounded payload tagged with its channel.
module udp_rx_mux #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic         i_sys_clk,
    input  logic         i_rstn,
    udp_rx_mux_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      hdr_cnt_q, hdr_cnt_d;
    logic [15:0]     src_port_q, src_port_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     rem_q, rem_d;

    logic            tab_en_q   [NUM_CH];
    logic            tab_en_d   [NUM_CH];
    logic [31:0]     tab_ip_q   [NUM_CH];
    logic [31:0]     tab_ip_d   [NUM_CH];
    logic [15:0]     tab_port_q [NUM_CH];
    logic [15:0]     tab_port_d [NUM_CH];

    logic            data_vld_q, data_vld_d;
    logic [7:0]      data_q, data_d;
    logic            data_last_q, data_last_d;
    logic [CH_W-1:0] ch_id_q, ch_id_d;
    logic            drop_q, drop_d;
    logic            len_err_q, len_err_d;

    logic            hit;
    logic [CH_W-1:0] hit_idx;

    // Indices with no matching entry simply never compare equal, so they are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tab_en_d[i]   = tab_en_q[i];
            tab_ip_d[i]   = tab_ip_q[i];
            tab_port_d[i] = tab_port_q[i];
            if (bus.i_cfg_we && bus.i_cfg_idx == CH_W'(i)) begin
                tab_en_d[i]   = bus.i_cfg_en;
                tab_ip_d[i]   = bus.i_cfg_ip;
                tab_port_d[i] = bus.i_cfg_port;
            end
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tab_en_q[i] && tab_ip_q[i] == bus.i_src_ip && tab_port_q[i] == src_port_q) begin
                hit     = 1'b1;
                hit_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        src_port_d  = src_port_q;
        len_d       = len_q;
        rem_d       = rem_q;
        data_vld_d  = 1'b0;
        data_d      = data_q;
        data_last_d = 1'b0;
        ch_id_d     = ch_id_q;
        drop_d      = 1'b0;
        len_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_datagram_vld) begin
                    src_port_d = {bus.i_datagram, src_port_q[7:0]};
                    hdr_cnt_d  = 3'd1;
                    state_d    = S_HEADER;
                end
            end

            S_HEADER: begin
                if (bus.i_drop_datagram) begin
                    drop_d  = 1'b1;
                    state_d = S_DISCARD;
                end else if (!bus.i_datagram_vld) begin
                    drop_d    = 1'b1;
                    len_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    // Destination port (bytes 2-3) and checksum (6-7) are not needed.
                    case (hdr_cnt_q)
                        3'd1: src_port_d = {src_port_q[15:8], bus.i_datagram};
                        3'd4: len_d      = {bus.i_datagram, len_q[7:0]};
                        3'd5: len_d      = {len_q[15:8], bus.i_datagram};
                        3'd7: begin
                            if (len_q < 16'd8) begin
                                drop_d    = 1'b1;
                                len_err_d = 1'b1;
                                state_d   = S_DISCARD;
                            end else if (!hit) begin
                                drop_d  = 1'b1;
                                state_d = S_DISCARD;
                            end else if (len_q == 16'd8) begin
                                state_d = S_DISCARD;
                            end else begin
                                ch_id_d = hit_idx;
                                rem_d   = len_q - 16'd8;
                                state_d = S_PAYLOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_PAYLOAD: begin
                if (bus.i_drop_datagram) begin
                    drop_d  = 1'b1;
                    state_d = S_DISCARD;
                end else if (!bus.i_datagram_vld) begin
                    drop_d    = 1'b1;
                    len_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    data_vld_d = 1'b1;
                    data_d     = bus.i_datagram;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        data_last_d = 1'b1;
                        state_d     = S_DISCARD;
                    end
                end
            end

            S_DISCARD: begin
                if (!bus.i_datagram_vld) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= '0;
            src_port_q  <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            data_vld_q  <= 1'b0;
            data_q      <= '0;
            data_last_q <= 1'b0;
            ch_id_q     <= '0;
            drop_q      <= 1'b0;
            len_err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                tab_en_q[i]   <= 1'b0;
                tab_ip_q[i]   <= '0;
                tab_port_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            src_port_q  <= src_port_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            data_vld_q  <= data_vld_d;
            data_q      <= data_d;
            data_last_q <= data_last_d;
            ch_id_q     <= ch_id_d;
            drop_q      <= drop_d;
            len_err_q   <= len_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tab_en_q[i]   <= tab_en_d[i];
                tab_ip_q[i]   <= tab_ip_d[i];
                tab_port_q[i] <= tab_port_d[i];
            end
        end
    end

    assign bus.o_data_vld      = data_vld_q;
    assign bus.o_data          = data_q;
    assign bus.o_data_last     = data_last_q;
    assign bus.o_ch_id         = ch_id_q;
    assign bus.o_drop_datagram = drop_q;
    assign bus.o_len_err       = len_err_q;

endmodule

// File: tb/tb_udp_rx_mux.sv
// tb/tb_udp_rx_mux.sv - directed bench for udp_rx_mux
module tb_udp_rx_mux;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam logic [31:0] IP5 = 32'h0A00_0005;
    localparam logic [31:0] IP7 = 32'h0A00_0007;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   orphan_len_err = 0;
    int   t0;
    int   t_save;

    logic [7:0]      tx[$];
    logic [7:0]      exp_q[$];
    logic [7:0]      rx_d[$];
    int              rx_c[$];
    logic            rx_l[$];
    logic [CH_W-1:0] rx_ch[$];
    int              dr_c[$];
    logic            dr_le[$];

    udp_rx_mux_if #(.CH_W(CH_W)) bus ();

    udp_rx_mux #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .i_sys_clk (clk),
        .i_rstn    (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_data_vld) begin
            rx_d.push_back(bus.o_data);
            rx_c.push_back(cyc);
            rx_l.push_back(bus.o_data_last);
            rx_ch.push_back(bus.o_ch_id);
        end
        if (bus.o_drop_datagram) begin
            dr_c.push_back(cyc);
            dr_le.push_back(bus.o_len_err);
        end
        if (bus.o_len_err && !bus.o_drop_datagram) orphan_len_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_rx();
        rx_d.delete(); rx_c.delete(); rx_l.delete(); rx_ch.delete();
        dr_c.delete(); dr_le.delete();
    endtask

    task automatic hdr(input logic [15:0] port, input logic [15:0] len);
        tx.delete();
        tx.push_back(port[15:8]); tx.push_back(port[7:0]);
        tx.push_back(8'h12);      tx.push_back(8'h34);
        tx.push_back(len[15:8]);  tx.push_back(len[7:0]);
        tx.push_back(8'h00);      tx.push_back(8'h00);
    endtask

    task automatic cfg(input logic [CH_W-1:0] idx, input logic en, input logic [31:0] ip,
                       input logic [15:0] port);
        bus.i_cfg_we = 1'b1; bus.i_cfg_idx = idx; bus.i_cfg_en = en;
        bus.i_cfg_ip = ip;   bus.i_cfg_port = port;
        @(posedge clk); #1;
        bus.i_cfg_we = 1'b0;
    endtask

    // Drives tx one byte per cycle, then exactly one idle cycle.
    task automatic send(input logic [31:0] ip, input int abort_at);
        t0 = cyc;
        for (int i = 0; i < tx.size(); i++) begin
            bus.i_src_ip        = ip;
            bus.i_datagram_vld  = 1'b1;
            bus.i_datagram      = tx[i];
            bus.i_drop_datagram = (i == abort_at);
            @(posedge clk); #1;
        end
        bus.i_datagram_vld  = 1'b0;
        bus.i_drop_datagram = 1'b0;
        bus.i_datagram      = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_rx(input string tag, input int first, input logic [CH_W-1:0] ch,
                          input logic want_last);
        chk({tag, "_cnt"}, 32'(rx_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_d.size()) begin
                chk({tag, "_dat"},  32'(rx_d[i]),  32'(exp_q[i]));
                chk({tag, "_cyc"},  rx_c[i],       first + i);
                chk({tag, "_ch"},   32'(rx_ch[i]), 32'(ch));
                chk({tag, "_last"}, 32'(rx_l[i]),  32'(want_last && (i == exp_q.size() - 1)));
            end
        end
    endtask

    task automatic chk_drop(input string tag, input int n, input int cyc_e, input logic le_e);
        chk({tag, "_drops"}, 32'(dr_c.size()), 32'(n));
        if (n > 0 && dr_c.size() > 0) begin
            chk({tag, "_dcyc"}, dr_c[0], cyc_e);
            chk({tag, "_lerr"}, 32'(dr_le[0]), 32'(le_e));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_datagram_vld = 1'b0; bus.i_datagram = 8'h00; bus.i_drop_datagram = 1'b0;
        bus.i_src_ip = 32'h0;      bus.i_cfg_we = 1'b0;    bus.i_cfg_idx = '0;
        bus.i_cfg_en = 1'b0;       bus.i_cfg_ip = 32'h0;   bus.i_cfg_port = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_vld",  32'(bus.o_data_vld), 32'h0);
        chk("rst_data", 32'(bus.o_data), 32'h0);
        chk("rst_last", 32'(bus.o_data_last), 32'h0);
        chk("rst_ch",   32'(bus.o_ch_id), 32'h0);
        chk("rst_drop", 32'(bus.o_drop_datagram), 32'h0);
        chk("rst_lerr", 32'(bus.o_len_err), 32'h0);

        cfg(2'd2, 1'b1, IP5, 16'h1F90);

        clear_rx(); hdr(16'h1F90, 16'd12);
        tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC); tx.push_back(8'hDD);
        send(IP5, -1); settle();
        exp_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk_rx("A", t0 + 9, 2'd2, 1'b1); chk_drop("A", 0, 0, 1'b0);

        clear_rx(); hdr(16'h1F90, 16'd10);
        tx.push_back(8'hAA); tx.push_back(8'hBB);
        for (int i = 0; i < 6; i++) tx.push_back(8'h11 + 8'(i));
        send(IP5, -1); settle();
        exp_q = {8'hAA, 8'hBB};
        chk_rx("B", t0 + 9, 2'd2, 1'b1); chk_drop("B", 0, 0, 1'b0);

        cfg(2'd1, 1'b1, IP7, 16'h2000);
        cfg(2'd3, 1'b1, IP7, 16'h2000);
        clear_rx(); hdr(16'h2000, 16'd9); tx.push_back(8'h5A);
        send(IP7, -1); settle();
        exp_q = {8'h5A};
        chk_rx("C1", t0 + 9, 2'd1, 1'b1); chk_drop("C1", 0, 0, 1'b0);
        cfg(2'd1, 1'b0, IP7, 16'h2000);
        clear_rx(); send(IP7, -1); settle();
        chk_rx("C2", t0 + 9, 2'd3, 1'b1); chk_drop("C2", 0, 0, 1'b0);

        clear_rx(); hdr(16'h1F91, 16'd12);
        tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC); tx.push_back(8'hDD);
        send(IP5, -1); settle();
        exp_q.delete();
        chk_rx("D", 0, 2'd0, 1'b0); chk_drop("D", 1, t0 + 8, 1'b0);

        clear_rx(); hdr(16'h1F90, 16'd6);
        send(IP5, -1); settle();
        chk_rx("E", 0, 2'd0, 1'b0); chk_drop("E", 1, t0 + 8, 1'b1);

        clear_rx(); hdr(16'h1F90, 16'd8);
        send(IP5, -1); settle();
        chk_rx("L8", 0, 2'd0, 1'b0); chk_drop("L8", 0, 0, 1'b0);

        clear_rx(); hdr(16'h1F90, 16'd20);
        for (int i = 1; i <= 5; i++) tx.push_back(8'(i));
        send(IP5, -1); settle();
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_rx("F", t0 + 9, 2'd2, 1'b0); chk_drop("F", 1, t0 + 14, 1'b1);

        clear_rx(); hdr(16'h1F90, 16'd12);
        tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC); tx.push_back(8'hDD);
        send(IP5, 10);
        exp_q = {8'hAA, 8'hBB};
        chk_rx("G1", t0 + 9, 2'd2, 1'b0); chk_drop("G1", 1, t0 + 11, 1'b0);
        t_save = t0;
        clear_rx(); send(IP5, -1); settle();
        exp_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk("G2_gap", t0 - t_save, 32'd13);
        chk_rx("G2", t0 + 9, 2'd2, 1'b1); chk_drop("G2", 0, 0, 1'b0);

        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("R_ch", 32'(bus.o_ch_id), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_rx(); send(IP5, -1); settle();
        exp_q.delete();
        chk_rx("R", 0, 2'd0, 1'b0); chk_drop("R", 1, t0 + 8, 1'b0);

        chk("orphan_lerr", orphan_len_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
